bitstream_scan_arbiter: RTL and testbench

//  Shares one serial pattern-scan engine between NREQ requesters, round-robin.
//  The granted requester's WIDTH-bit word is latched and shifted MSB-first through
//  a PLEN-bit window that is compared against a programmable pattern, e.g. 4'b1011.
//  The block counts matches and returns the count with a one-cycle done strobe.

---
 rtl/bscan_pkg.sv | 20 ++
 rtl/scan_window.sv | 52 +++++
 rtl/bitstream_scan_arbiter.sv | 156 +++++++++++++++
 tb/tb_bitstream_scan_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bscan_pkg.sv
// Shared types and width helpers for the bitstream scan arbiter.
// State encoding is fixed at 2 bits so checkers can bind to it directly.
package bscan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    REPORT = 2'd3
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int id_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/scan_window.sv
// PLEN-bit sliding window, fill counter and pattern compare for one serial stream.
// BSCAN_OVERLAP_EN keeps the window after a hit; otherwise fill restarts so hits never overlap.
module scan_window
  import bscan_pkg::*;
#(
  parameter int PLEN = 4
) (
  input  logic            ck,
  input  logic            rs,
  input  logic            clr,
  input  logic            en,
  input  logic            x,
  input  logic [PLEN-1:0] pattern,
  output logic            hit
);

  localparam int FW = cnt_w(PLEN);

  logic [PLEN-1:0] window;
  logic [PLEN-1:0] win_base;
  logic [PLEN-1:0] win_nxt;
  logic [FW-1:0]   fill;
  logic [FW-1:0]   fill_base;
  logic [FW-1:0]   fill_nxt;

  // clr and en may coincide: the first bit enters an already-cleared window.
  always_comb begin
    win_base  = clr ? '0 : window;
    fill_base = clr ? '0 : fill;
    win_nxt   = (win_base << 1) | PLEN'(x);
    fill_nxt  = (fill_base == FW'(PLEN)) ? fill_base : fill_base + 1'b1;
    hit       = en && (fill_nxt == FW'(PLEN)) && (win_nxt == pattern);
  end

  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      window <= '0;
      fill   <= '0;
    end else if (en) begin
      window <= win_nxt;
`ifdef BSCAN_OVERLAP_EN
      fill   <= fill_nxt;
`else
      fill   <= hit ? '0 : fill_nxt;
`endif
    end else if (clr) begin
      window <= '0;
      fill   <= '0;
    end
  end

endmodule

// File: rtl/bitstream_scan_arbiter.sv
// Round-robin arbiter sharing one MSB-first serial pattern-scan engine among NREQ requesters.
// Overlapping-match counting is selected with the BSCAN_OVERLAP_EN macro (see scan_window).
module bitstream_scan_arbiter
  import bscan_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8,
  parameter int PLEN  = 4
) (
  input  logic                      ck,
  input  logic                      rs,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     data,
  input  logic [PLEN-1:0]           pattern,
  output logic [NREQ-1:0]           gnt,
  output logic                      busy,
  output logic                      done,
  output logic [id_w(NREQ)-1:0]     done_id,
  output logic [cnt_w(WIDTH)-1:0]   match_cnt,
  output logic                      ser_x,
  output logic                      ser_y
);

  localparam int IW = id_w(NREQ);
  localparam int CW = cnt_w(WIDTH);

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   pick;
  logic            pick_valid;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] sh;
  logic [PLEN-1:0] pat_q;
  logic [PLEN-1:0] pat_cur;
  logic [CW-1:0]   bit_cnt;
  logic [CW-1:0]   cnt;
  logic            last_bit;
  logic            shift_en;
  logic            x;
  logic            hit;

  // Lowest index above ptr wins; if none, lowest index at or below ptr (wrap).
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[j] && IW'(j) <= ptr) begin
        pick       = IW'(j);
        pick_valid = 1'b1;
      end
    end
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[j] && IW'(j) > ptr) begin
        pick       = IW'(j);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    word = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (sel == IW'(j)) word = data[j*WIDTH +: WIDTH];
    end
  end

  // The first bit is shifted on the LOAD edge so SHIFT spans exactly WIDTH cycles.
  assign last_bit = (bit_cnt == CW'(WIDTH - 1));
  assign shift_en = (state == LOAD) || (state == SHIFT && !last_bit);
  assign x        = (state == LOAD) ? word[WIDTH-1] : sh[WIDTH-1];
  assign pat_cur  = (state == LOAD) ? pattern : pat_q;

  scan_window #(.PLEN(PLEN)) u_window (
    .ck      (ck),
    .rs      (rs),
    .clr     (state == LOAD),
    .en      (shift_en),
    .x       (x),
    .pattern (pat_cur),
    .hit     (hit)
  );

  always_ff @(posedge ck or posedge rs) begin
    if (rs) state <= IDLE;
    else    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_valid) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      ptr       <= IW'(NREQ - 1);
      sel       <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
      ser_x     <= 1'b0;
      ser_y     <= 1'b0;
      sh        <= '0;
      pat_q     <= '0;
      bit_cnt   <= '0;
      cnt       <= '0;
    end else begin
      gnt   <= '0;
      done  <= 1'b0;
      ser_x <= 1'b0;
      ser_y <= 1'b0;
      busy  <= (state_nxt != IDLE);
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            sel <= pick;
            gnt <= NREQ'(1) << pick;
          end
        end
        LOAD: begin
          ptr     <= sel;
          pat_q   <= pattern;
          sh      <= word << 1;
          bit_cnt <= '0;
          cnt     <= CW'(hit);
          ser_x   <= x;
          ser_y   <= hit;
        end
        SHIFT: begin
          if (!last_bit) begin
            sh      <= sh << 1;
            bit_cnt <= bit_cnt + 1'b1;
            cnt     <= cnt + CW'(hit);
            ser_x   <= x;
            ser_y   <= hit;
          end else begin
            done      <= 1'b1;
            done_id   <= sel;
            match_cnt <= cnt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_scan_arbiter.sv
// Directed plus randomized bench for bitstream_scan_arbiter against a substring-count model.
module tb_bitstream_scan_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 8;
  localparam int P    = 4;
  localparam int CW   = $clog2(W + 1);
  localparam int IW   = $clog2(NREQ);
`ifdef BSCAN_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  logic              ck = 1'b0;
  logic              rs;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] data;
  logic [P-1:0]      pattern;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              done;
  logic [IW-1:0]     done_id;
  logic [CW-1:0]     match_cnt;
  logic              ser_x;
  logic              ser_y;

  int checks = 0;
  int errors = 0;
  int last_id;
  logic [CW-1:0] exp_q[$];

  bitstream_scan_arbiter #(.NREQ(NREQ), .WIDTH(W), .PLEN(P)) dut (
    .ck        (ck),
    .rs        (rs),
    .req       (req),
    .data      (data),
    .pattern   (pattern),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt),
    .ser_x     (ser_x),
    .ser_y     (ser_y)
  );

  // clock / reset
  always #5 ck = ~ck;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Count PLEN-bit substrings of word (MSB first) equal to pat; mask marks the bit ending each hit.
  function automatic void model(input logic [W-1:0] word, input logic [P-1:0] pat,
                                output int cnt, output logic [W-1:0] mask);
    int start;
    bit m;
    cnt   = 0;
    mask  = '0;
    start = 0;
    for (int e = P - 1; e < W; e++) begin
      if (e - P + 1 >= start) begin
        m = 1'b1;
        for (int j = 0; j < P; j++)
          if (word[W-1-(e-P+1+j)] != pat[P-1-j]) m = 1'b0;
        if (m) begin
          cnt++;
          mask[e] = 1'b1;
          if (!OVERLAP) start = e + 1;
        end
      end
    end
  endfunction

  function automatic int rr_next(input logic [NREQ-1:0] r, input int last);
    for (int i = 1; i <= NREQ; i++)
      if (r[(last + i) % NREQ]) return (last + i) % NREQ;
    return -1;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_serx"}, ser_x, 0);
    chk({tag, "_sery"}, ser_y, 0);
  endtask

  // Entered at the negedge of the LOAD cycle; returns at the negedge of the done cycle.
  task automatic scan_body(input int id, input logic [W-1:0] word, input logic [P-1:0] pat,
                           input bit hold, input bit raise_other);
    int cnt;
    logic [W-1:0] mask;
    logic [CW-1:0] e;
    model(word, pat, cnt, mask);
    exp_q.push_back(CW'(cnt));
    last_id = id;
    chk("load_busy", busy, 1);
    for (int b = 0; b < W; b++) begin
      @(negedge ck);
      if (b == 0 && !hold) req[id] = 1'b0;
      chk("ser_x", ser_x, word[W-1-b]);
      chk("ser_y", ser_y, mask[b]);
      chk("shift_busy", busy, 1);
      chk("early_done", done, 0);
      if (raise_other && b == 3) begin
        req[(id + 1) % NREQ] = 1'b1;
        pattern = ~pattern;
      end
    end
    @(negedge ck);
    chk("done", done, 1);
    chk("done_id", done_id, id);
    chk("report_ser", {ser_x, ser_y}, 0);
    if (exp_q.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = exp_q.pop_front();
      chk("match_cnt", match_cnt, e);
    end
  endtask

  // Called at a negedge with the engine idle.
  task automatic do_scan(input int id, input logic [W-1:0] word, input logic [P-1:0] pat);
    int expid;
    int n;
    data[id*W +: W] = word;
    pattern = pat;
    req[id] = 1'b1;
    expid = rr_next(req, last_id);
    @(negedge ck);
    chk("gnt_latency", gnt, 1 << expid);
    n = 0;
    while (gnt == '0 && n < 40) begin
      @(negedge ck);
      n++;
    end
    if (gnt == '0) begin
      chk("gnt_timeout", 0, 1);
      req = '0;
    end else begin
      scan_body(id, word, pat, 1'b0, 1'b0);
      @(negedge ck);
      chk("post_busy", busy, 0);
      chk("post_done", done, 0);
    end
  endtask

  initial begin
    logic [W-1:0] d0, d1;
    logic [P-1:0] p1;
    int expid;

    rs = 1'b1;
    req = '0;
    data = '0;
    pattern = '0;
    repeat (2) @(negedge ck);
    chk_quiet("reset");
    chk("reset_done_id", done_id, 0);
    chk("reset_cnt", match_cnt, 0);
    rs = 1'b0;
    last_id = NREQ - 1;
    @(negedge ck);

    // Reference word from the datasheet.
    do_scan(0, 8'hB7, 4'b1011);
    chk("b7_cnt", match_cnt, OVERLAP ? 2 : 1);

    // Degenerate words.
    do_scan(1, 8'h00, 4'b1011);
    chk("zero_cnt", match_cnt, 0);
    do_scan(0, 8'hFF, 4'b1111);
    chk("ones_cnt", match_cnt, OVERLAP ? 5 : 2);

    // Second requester arrives mid-scan while the pattern input changes.
    d0 = W'($urandom);
    d1 = W'($urandom);
    p1 = d0[W-1:W-P];
    data = {d1, d0};
    pattern = p1;
    req = 2'b01;
    @(negedge ck);
    chk("mid_gnt0", gnt, 2'b01);
    scan_body(0, d0, p1, 1'b0, 1'b1);
    @(negedge ck);
    chk("mid_idle_gnt", gnt, 0);
    chk("mid_idle_busy", busy, 0);
    @(negedge ck);
    chk("mid_gnt1", gnt, 2'b10);
    scan_body(1, d1, ~p1, 1'b0, 1'b0);
    @(negedge ck);
    chk_quiet("mid_end");

    // Both requests held: grants alternate.
    data = {W'($urandom), W'($urandom)};
    pattern = P'($urandom);
    req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      @(negedge ck);
      if (g > 0) begin
        chk("alt_idle_gnt", gnt, 0);
        @(negedge ck);
      end
      expid = rr_next(req, last_id);
      chk("alt_gnt", gnt, 1 << expid);
      scan_body(expid, data[expid*W +: W], pattern, 1'b1, 1'b0);
    end
    req = '0;
    @(negedge ck);
    @(negedge ck);
    chk_quiet("alt_end");

    // Reset in the middle of a scan.
    data[W-1:0] = W'($urandom);
    req = 2'b01;
    @(negedge ck);
    chk("rst_gnt", gnt, 2'b01);
    repeat (3) @(negedge ck);
    rs = 1'b1;
    req = '0;
    @(negedge ck);
    chk_quiet("midrst");
    chk("midrst_done_id", done_id, 0);
    chk("midrst_cnt", match_cnt, 0);
    rs = 1'b0;
    last_id = NREQ - 1;
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge ck);
      chk("midrst_no_done", done, 0);
    end
    data = {W'($urandom), W'($urandom)};
    req = 2'b11;
    @(negedge ck);
    chk("rst_rr_first", gnt, 2'b01);
    scan_body(0, data[W-1:0], pattern, 1'b0, 1'b0);
    @(negedge ck);
    @(negedge ck);
    chk("rst_rr_second", gnt, 2'b10);
    scan_body(1, data[2*W-1:W], pattern, 1'b0, 1'b0);
    @(negedge ck);
    chk_quiet("rst_end");

    // Randomized single-requester scans.
    for (int i = 0; i < 16; i++) begin
      d0 = W'($urandom);
      p1 = ($urandom_range(0, 1) == 1) ? d0[W-1-$urandom_range(0, W-P) -: P] : P'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge ck);
      do_scan($urandom_range(0, NREQ - 1), d0, p1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
